// File: rtl/trig_sched_pkg.sv
// trig_sched_pkg
// Shared types and constants for the trig_sched round-robin trigger scheduler.
// Ports: none (package).
//   sched_state_t : FSM state encoding (IDLE, SHIFT, GAP)
//   CNT_W         : width of the shared bit/gap down-counter, sized to hold
//                   the largest load value (WIDTH-1 <= 31, GAP-1 <= 14)

package trig_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } sched_state_t;

  localparam int CNT_W = $clog2(32);

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter. The search starts one index past the
// previous winner and wraps, so the previous winner has the lowest priority.
// Ports:
//   req     in  NREQ          : request levels
//   last    in  clog2(NREQ)   : index of the previous winner
//   win     out NREQ          : one-hot winner (all zero when no request)
//   win_idx out clog2(NREQ)   : encoded winner index (0 when no request)

module rr_arbiter
  import trig_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [NREQ-1:0]         win,
  output logic [$clog2(NREQ)-1:0] win_idx
);

  localparam int IDX_W = $clog2(NREQ);

  logic found;
  int   idx;

  // Walk the requesters starting at last+1; the first asserted one wins and
  // the found flag masks every later candidate.
  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        win[idx] = 1'b1;
        win_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/trig_sched.sv
// trig_sched
// Round-robin scheduler sharing one triggered serial line among NREQ
// requesters. A granted payload is shifted out MSB first while trig is high,
// followed by GAP forced idle cycles.
// Ports:
//   clk      in  1           : clock, rising edge
//   rst_n    in  1           : synchronous active-low reset
//   req      in  NREQ        : request levels, sampled only in IDLE
//   payload  in  NREQ*WIDTH  : requester i at [i*WIDTH +: WIDTH]
//   gnt      out NREQ        : one-hot, one-cycle accept pulse
//   trig     out 1           : frame bit valid on data_o
//   data_o   out 1           : serial data, 0 when trig is 0
//   busy     out 1           : high from accept until back in IDLE

module trig_sched
  import trig_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] payload,
  output logic [NREQ-1:0]       gnt,
  output logic                  trig,
  output logic                  data_o,
  output logic                  busy
);

  localparam int IDX_W = $clog2(NREQ);
  localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

  sched_state_t     state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] last, last_n;
  logic [IDX_W-1:0] win_idx;
  logic [NREQ-1:0]  win;
  logic [NREQ-1:0]  gnt_n;
  logic             trig_n, data_n, busy_n;
  logic [WIDTH-1:0] sel_payload;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .req    (req),
    .last   (last),
    .win    (win),
    .win_idx(win_idx)
  );

  assign sel_payload = payload[win_idx*WIDTH +: WIDTH];

  // Next-state logic. Outputs are computed from the next state/shift value
  // and registered, so trig/data_o/busy/gnt change exactly on the edge that
  // moves the FSM and nothing combinational reaches the ports. One counter
  // serves both SHIFT (bits left) and GAP (idle cycles left).
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    last_n  = last;
    gnt_n   = '0;
    trig_n  = 1'b0;
    data_n  = 1'b0;
    busy_n  = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_n = SHIFT;
          shreg_n = sel_payload;
          cnt_n   = BIT_LOAD;
          last_n  = win_idx;
          gnt_n   = win;
          trig_n  = 1'b1;
          data_n  = sel_payload[WIDTH-1];
          busy_n  = 1'b1;
        end
      end
      SHIFT: begin
        shreg_n = shreg << 1;
        if (cnt == '0) begin
          if (GAP == 0) begin
            state_n = IDLE;
          end else begin
            state_n = trig_sched_pkg::GAP;
            cnt_n   = GAP_LOAD;
            busy_n  = 1'b1;
          end
        end else begin
          cnt_n  = cnt - 1'b1;
          trig_n = 1'b1;
          data_n = shreg_n[WIDTH-1];
          busy_n = 1'b1;
        end
      end
      trig_sched_pkg::GAP: begin
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n  = cnt - 1'b1;
          busy_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      last   <= LAST_RST;
      gnt    <= '0;
      trig   <= 1'b0;
      data_o <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      shreg  <= shreg_n;
      cnt    <= cnt_n;
      last   <= last_n;
      gnt    <= gnt_n;
      trig   <= trig_n;
      data_o <= data_n;
      busy   <= busy_n;
    end
  end

endmodule
